sauria_cfg_sequencer: RTL and testbench
=======================================

# sauria_cfg_sequencer

Single-master AXI4 configuration sequencer that programs the SAURIA accelerator through the struct-side AXI port of the SoC/accelerator bridge. On a start pulse it issues a table of single-beat register writes, then optionally polls a status register until a masked condition holds. It reports done or error to the host. It sits between the host control logic and the AXI struct-to-interface bridge feeding SAURIA's configuration slave.

## Interface
Parameters:
- axi_req_t, logic: AXI4 request struct (AW/W/AR channels plus b_ready, r_ready).
- axi_resp_t, logic: AXI4 response struct.
- AddrWidth, 32: AXI address width.
- DataWidth, 32: AXI data width; must be 32 or 64.
- NumCfg, 8: maximum number of table entries.
- MaxPolls, 1024: read attempts before a timeout.
- PollGap, 4: idle cycles between poll reads; 0 is legal.

Ports (one clock; reset is synchronous and active-low):
- clk_i  in  1  clock; all state on rising edge.
- rst_ni  in  1  synchronous active-low reset.
- start_i  in  1  start request; sampled only in IDLE.
- num_cfg_i  in  $clog2(NumCfg+1)  entries to write; 0 skips the write phase.
- cfg_addr_i  in  NumCfg x AddrWidth  write addresses; must be stable while busy_o.
- cfg_data_i  in  NumCfg x DataWidth  write data; must be stable while busy_o.
- poll_en_i  in  1  enables the poll phase.
- poll_addr_i  in  AddrWidth  status register address.
- poll_mask_i  in  DataWidth  done condition is (rdata & mask) == mask.
- axi_req_o  out  axi_req_t  to the bridge.
- axi_rsp_i  in  axi_resp_t  from the bridge.
- busy_o  out  1  high from the cycle after accepted start until DONE/ERR.
- done_o  out  1  one-cycle pulse on successful completion.
- error_o  out  1  one-cycle pulse on failure.
- err_code_o  out  2  0 none, 1 write BRESP error, 2 read RRESP error, 3 poll timeout; held until the next start.

## Operation
- States: IDLE, WR_REQ, WR_RSP, POLL_AR, POLL_R, POLL_GAP, DONE, ERR.
- IDLE, start_i=1:
  - clear err_code_o and the entry index.
  - go to WR_REQ if num_cfg_i>0; else POLL_AR if poll_en_i; else DONE.
- WR_REQ:
  - aw_valid and w_valid rise together, carrying entry[idx].
  - Each drops independently after its own handshake; the flags aw_done and w_done track this.
  - Go to WR_RSP once both handshakes have occurred. Handshakes may complete in the same or different cycles.
- WR_RSP:
  - b_ready=1.
  - On b_valid with BRESP != OKAY: go to ERR with code 1.
  - On OKAY and idx==num_cfg_i-1: go to POLL_AR if poll_en_i, else DONE.
  - Otherwise increment idx and return to WR_REQ.
- POLL_AR:
  - ar_valid=1 with poll_addr_i.
  - On handshake, increment the poll counter and go to POLL_R.
- POLL_R:
  - r_ready=1. On r_valid:
    - RRESP != OKAY: go to ERR with code 2.
    - Condition met: go to DONE.
    - Poll counter == MaxPolls: go to ERR with code 3.
    - Otherwise go to POLL_GAP, or to POLL_AR directly if PollGap==0.
- POLL_GAP: count PollGap cycles, then go to POLL_AR.
- DONE pulses done_o; ERR pulses error_o. Both return to IDLE on the next cycle.
- Fixed AXI fields on every request:
  - id 0, len 0, size $clog2(DataWidth/8), burst INCR.
  - w_strb all ones, w_last 1.
  - lock, cache, prot, qos, region, atop and user all 0.
- Once valid is raised, it is never withdrawn before its handshake, and the payload stays stable.
- start_i while busy_o is ignored, with no queueing.

## Timing
- Reset: every valid and ready in axi_req_o is 0 and all payload fields are 0. busy_o, done_o and error_o are 0, err_code_o is 0, the state is IDLE and all counters are 0.
- Reset asserted mid-transaction abandons it immediately. Valids drop in the reset cycle, with no drain. The system resets the SAURIA slave together with this block.
- Request valids and readies are registered state decodes. They appear the cycle after the state is entered, with no combinational path from axi_rsp_i.
- start accepted at cycle t:
  - busy_o=1 and aw_valid/w_valid=1 at t+1.
- With zero-wait slave handshakes:
  - each write takes 2 cycles (WR_REQ, WR_RSP).
  - each poll takes 2+PollGap cycles.
- done_o or error_o is asserted in the cycle after the last response. busy_o falls in that same cycle.
- b_valid is not expected before both AW and W handshakes. It is only accepted in WR_RSP.

## Structure
- Package sauria_cfg_seq_pkg holds:
  - the state enum;
  - the err_code enum (ERR_NONE, ERR_BRESP, ERR_RRESP, ERR_TIMEOUT);
  - AXI constants RESP_OKAY=2'b00 and BURST_INCR=2'b01.
- Single module with no sub-module.
- Poll and gap counters are sized $clog2(MaxPolls+1) and $clog2(PollGap+1).

## Test plan
- num_cfg=3 (0x0:0x11, 0x4:0x22, 0x8:0x33), poll off, zero-wait slave:
  - exactly 3 AW/W pairs in order; done_o at t+7; err_code 0.
- Slave accepts W 3 cycles before AW on entry 0:
  - a single W beat only, with no duplicate.
  - WR_RSP is entered only after AW; data 0x11 lands at 0x0.
- Second write returns BRESP=SLVERR:
  - error_o pulse; err_code 1; third write is never issued; busy_o falls in the same cycle.
- Poll at 0x100, mask 0x1; status reads 0, 0, 1; PollGap=4:
  - 3 AR handshakes spaced 6 cycles apart; done_o after the third R.
- MaxPolls=4 and status stays 0:
  - exactly 4 AR handshakes, then error_o with err_code 3.
- Reset held low for 1 cycle while aw_valid=1, then start re-pulsed:
  - all valids drop during reset; IDLE state.
  - fresh sequence restarts from entry 0.

Source files
------------

// File: rtl/sauria_cfg_seq_pkg.sv
// Shared types and constants for the SAURIA configuration sequencer.
package sauria_cfg_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_REQ   = 3'd1,
        ST_WR_RSP   = 3'd2,
        ST_POLL_AR  = 3'd3,
        ST_POLL_R   = 3'd4,
        ST_POLL_GAP = 3'd5,
        ST_DONE     = 3'd6,
        ST_ERR      = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BRESP   = 2'd1,
        ERR_RRESP   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;

    // Default AXI4 struct shapes, matching the default 32-bit address/data widths.
    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ID_W   = 4;
    localparam int unsigned DEF_USER_W = 1;

    typedef struct packed {
        logic [DEF_ID_W-1:0]   id;
        logic [DEF_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [5:0]            atop;
        logic [DEF_USER_W-1:0] user;
    } axi_def_aw_t;

    typedef struct packed {
        logic [DEF_ID_W-1:0]   id;
        logic [DEF_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [DEF_USER_W-1:0] user;
    } axi_def_ar_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0]   data;
        logic [DEF_DATA_W/8-1:0] strb;
        logic                    last;
        logic [DEF_USER_W-1:0]   user;
    } axi_def_w_t;

    typedef struct packed {
        logic [DEF_ID_W-1:0]   id;
        logic [1:0]            resp;
        logic [DEF_USER_W-1:0] user;
    } axi_def_b_t;

    typedef struct packed {
        logic [DEF_ID_W-1:0]   id;
        logic [DEF_DATA_W-1:0] data;
        logic [1:0]            resp;
        logic                  last;
        logic [DEF_USER_W-1:0] user;
    } axi_def_r_t;

    typedef struct packed {
        axi_def_aw_t aw;
        logic        aw_valid;
        axi_def_w_t  w;
        logic        w_valid;
        logic        b_ready;
        axi_def_ar_t ar;
        logic        ar_valid;
        logic        r_ready;
    } axi_def_req_t;

    typedef struct packed {
        logic       aw_ready;
        logic       ar_ready;
        logic       w_ready;
        logic       b_valid;
        axi_def_b_t b;
        logic       r_valid;
        axi_def_r_t r;
    } axi_def_resp_t;

    // AXI size encoding for a full-width beat.
    function automatic logic [2:0] axi_size_f(input int unsigned data_width);
        logic [2:0] size_v;
        case (data_width)
            32'd8:   size_v = 3'd0;
            32'd16:  size_v = 3'd1;
            32'd32:  size_v = 3'd2;
            32'd64:  size_v = 3'd3;
            32'd128: size_v = 3'd4;
            default: size_v = 3'd2;
        endcase
        return size_v;
    endfunction

endpackage

// File: rtl/sauria_cfg_sequencer.sv
// Programs SAURIA through AXI: a table of single-beat writes, then an optional
// status poll until (rdata & mask) == mask, reporting done or error.
module sauria_cfg_sequencer
    import sauria_cfg_seq_pkg::*;
#(
    parameter type         axi_req_t  = axi_def_req_t,
    parameter type         axi_resp_t = axi_def_resp_t,
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned NumCfg     = 8,
    parameter int unsigned MaxPolls   = 1024,
    parameter int unsigned PollGap    = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                start_i,
    input  logic [$clog2(NumCfg+1)-1:0]         num_cfg_i,
    input  logic [NumCfg-1:0][AddrWidth-1:0]    cfg_addr_i,
    input  logic [NumCfg-1:0][DataWidth-1:0]    cfg_data_i,
    input  logic                                poll_en_i,
    input  logic [AddrWidth-1:0]                poll_addr_i,
    input  logic [DataWidth-1:0]                poll_mask_i,
    output axi_req_t                            axi_req_o,
    input  axi_resp_t                           axi_rsp_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                error_o,
    output logic [1:0]                          err_code_o
);

    localparam int unsigned CNT_W  = $clog2(NumCfg + 1);
    localparam int unsigned IDX_W  = (NumCfg > 1) ? $clog2(NumCfg) : 1;
    localparam int unsigned PCNT_W = $clog2(MaxPolls + 1);
    localparam int unsigned GAP_W  = (PollGap > 0) ? $clog2(PollGap + 1) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((PollGap > 0) ? PollGap - 1 : 0);
    localparam logic [PCNT_W-1:0] POLL_MAX = PCNT_W'(MaxPolls);
    localparam logic [2:0]        AXI_SIZE = axi_size_f(DataWidth);

    state_e              state_r, state_s;
    logic [IDX_W-1:0]    idx_r, idx_s;
    logic                aw_done_r, aw_done_s;
    logic                w_done_r, w_done_s;
    logic [PCNT_W-1:0]   poll_cnt_r, poll_cnt_s;
    logic [GAP_W-1:0]    gap_cnt_r, gap_cnt_s;
    err_code_e           err_code_r, err_code_s;

    logic                aw_valid_r, w_valid_r, b_ready_r, ar_valid_r, r_ready_r;
    logic [AddrWidth-1:0] aw_addr_r, ar_addr_r;
    logic [DataWidth-1:0] w_data_r;
    logic                busy_r, done_r, error_r;

    logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, last_entry_s, poll_hit_s;
    logic unused_rsp_s;

    assign aw_hs_s      = aw_valid_r & axi_rsp_i.aw_ready;
    assign w_hs_s       = w_valid_r  & axi_rsp_i.w_ready;
    assign b_hs_s       = b_ready_r  & axi_rsp_i.b_valid;
    assign ar_hs_s      = ar_valid_r & axi_rsp_i.ar_ready;
    assign r_hs_s       = r_ready_r  & axi_rsp_i.r_valid;
    assign last_entry_s = ((CNT_W'(idx_r) + CNT_W'(1)) == num_cfg_i);
    assign poll_hit_s   = ((axi_rsp_i.r.data & poll_mask_i) == poll_mask_i);
    // Response fields this master never looks at (ids, user, last).
    assign unused_rsp_s = ^{axi_rsp_i};

    // Next-state and counter logic.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        aw_done_s  = 1'b0;
        w_done_s   = 1'b0;
        poll_cnt_s = poll_cnt_r;
        gap_cnt_s  = gap_cnt_r;
        err_code_s = err_code_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    err_code_s = ERR_NONE;
                    idx_s      = '0;
                    poll_cnt_s = '0;
                    gap_cnt_s  = '0;
                    if (num_cfg_i != '0) begin
                        state_s = ST_WR_REQ;
                    end else if (poll_en_i) begin
                        state_s = ST_POLL_AR;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WR_REQ: begin
                aw_done_s = aw_done_r | aw_hs_s;
                w_done_s  = w_done_r  | w_hs_s;
                if (aw_done_s && w_done_s) begin
                    state_s   = ST_WR_RSP;
                    aw_done_s = 1'b0;
                    w_done_s  = 1'b0;
                end else begin
                    state_s = ST_WR_REQ;
                end
            end
            ST_WR_RSP: begin
                if (b_hs_s) begin
                    if (axi_rsp_i.b.resp != RESP_OKAY) begin
                        state_s    = ST_ERR;
                        err_code_s = ERR_BRESP;
                    end else if (last_entry_s) begin
                        state_s = poll_en_i ? ST_POLL_AR : ST_DONE;
                    end else begin
                        idx_s   = idx_r + IDX_W'(1);
                        state_s = ST_WR_REQ;
                    end
                end else begin
                    state_s = ST_WR_RSP;
                end
            end
            ST_POLL_AR: begin
                if (ar_hs_s) begin
                    poll_cnt_s = poll_cnt_r + PCNT_W'(1);
                    state_s    = ST_POLL_R;
                end else begin
                    state_s = ST_POLL_AR;
                end
            end
            ST_POLL_R: begin
                if (r_hs_s) begin
                    if (axi_rsp_i.r.resp != RESP_OKAY) begin
                        state_s    = ST_ERR;
                        err_code_s = ERR_RRESP;
                    end else if (poll_hit_s) begin
                        state_s = ST_DONE;
                    end else if (poll_cnt_r == POLL_MAX) begin
                        state_s    = ST_ERR;
                        err_code_s = ERR_TIMEOUT;
                    end else if (PollGap == 0) begin
                        state_s = ST_POLL_AR;
                    end else begin
                        gap_cnt_s = '0;
                        state_s   = ST_POLL_GAP;
                    end
                end else begin
                    state_s = ST_POLL_R;
                end
            end
            ST_POLL_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    gap_cnt_s = '0;
                    state_s   = ST_POLL_AR;
                end else begin
                    gap_cnt_s = gap_cnt_r + GAP_W'(1);
                    state_s   = ST_POLL_GAP;
                end
            end
            ST_DONE:  state_s = ST_IDLE;
            ST_ERR:   state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r    <= ST_IDLE;
            idx_r      <= '0;
            aw_done_r  <= 1'b0;
            w_done_r   <= 1'b0;
            poll_cnt_r <= '0;
            gap_cnt_r  <= '0;
            err_code_r <= ERR_NONE;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            aw_done_r  <= aw_done_s;
            w_done_r   <= w_done_s;
            poll_cnt_r <= poll_cnt_s;
            gap_cnt_r  <= gap_cnt_s;
            err_code_r <= err_code_s;
        end
    end

    // Registered handshake strobes, payloads and status, decoded from the next state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            aw_valid_r <= 1'b0;
            w_valid_r  <= 1'b0;
            b_ready_r  <= 1'b0;
            ar_valid_r <= 1'b0;
            r_ready_r  <= 1'b0;
            aw_addr_r  <= '0;
            w_data_r   <= '0;
            ar_addr_r  <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            aw_valid_r <= (state_s == ST_WR_REQ) && !aw_done_s;
            w_valid_r  <= (state_s == ST_WR_REQ) && !w_done_s;
            b_ready_r  <= (state_s == ST_WR_RSP);
            ar_valid_r <= (state_s == ST_POLL_AR);
            r_ready_r  <= (state_s == ST_POLL_R);
            busy_r     <= (state_s inside {ST_WR_REQ, ST_WR_RSP, ST_POLL_AR, ST_POLL_R, ST_POLL_GAP});
            done_r     <= (state_s == ST_DONE);
            error_r    <= (state_s == ST_ERR);
            if (state_s == ST_WR_REQ) begin
                aw_addr_r <= cfg_addr_i[idx_s];
                w_data_r  <= cfg_data_i[idx_s];
            end else begin
                aw_addr_r <= aw_addr_r;
                w_data_r  <= w_data_r;
            end
            if (state_s == ST_POLL_AR) begin
                ar_addr_r <= poll_addr_i;
            end else begin
                ar_addr_r <= ar_addr_r;
            end
        end
    end

    // Request assembly; fixed fields appear only alongside their valid so reset drives all zeros.
    always_comb begin
        axi_req_o          = '0;
        axi_req_o.aw_valid = aw_valid_r;
        axi_req_o.aw.addr  = aw_addr_r;
        axi_req_o.aw.size  = aw_valid_r ? AXI_SIZE : 3'd0;
        axi_req_o.aw.burst = aw_valid_r ? BURST_INCR : 2'b00;
        axi_req_o.w_valid  = w_valid_r;
        axi_req_o.w.data   = w_data_r;
        axi_req_o.w.strb   = {(DataWidth/8){w_valid_r}};
        axi_req_o.w.last   = w_valid_r;
        axi_req_o.b_ready  = b_ready_r;
        axi_req_o.ar_valid = ar_valid_r;
        axi_req_o.ar.addr  = ar_addr_r;
        axi_req_o.ar.size  = ar_valid_r ? AXI_SIZE : 3'd0;
        axi_req_o.ar.burst = ar_valid_r ? BURST_INCR : 2'b00;
        axi_req_o.r_ready  = r_ready_r;
    end

    assign busy_o     = busy_r;
    assign done_o     = done_r;
    assign error_o    = error_r;
    assign err_code_o = err_code_r;

endmodule

// File: tb/tb_sauria_cfg_sequencer.sv
// Directed bench for sauria_cfg_sequencer with a reactive AXI slave model.
module tb_sauria_cfg_sequencer;
    import sauria_cfg_seq_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, start, poll_en;
    logic [3:0]         num_cfg;
    logic [7:0][31:0]   cfg_addr, cfg_data;
    logic [31:0]        poll_addr, poll_mask;
    axi_def_req_t       req;
    axi_def_resp_t      rsp;
    logic               busy, done, error;
    logic [1:0]         err_code;

    sauria_cfg_sequencer #(
        .axi_req_t (axi_def_req_t),
        .axi_resp_t(axi_def_resp_t),
        .AddrWidth (32),
        .DataWidth (32),
        .NumCfg    (8),
        .MaxPolls  (4),
        .PollGap   (4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .num_cfg_i  (num_cfg),
        .cfg_addr_i (cfg_addr),
        .cfg_data_i (cfg_data),
        .poll_en_i  (poll_en),
        .poll_addr_i(poll_addr),
        .poll_mask_i(poll_mask),
        .axi_req_o  (req),
        .axi_rsp_i  (rsp),
        .busy_o     (busy),
        .done_o     (done),
        .error_o    (error),
        .err_code_o (err_code)
    );

    // Slave knobs (written by the test) and slave state/logs (written by the slave).
    int          aw_wait = 0, w_wait = 0, err_idx = -1;
    logic [31:0] stat [4];
    int          cyc = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int          aw_wc = 0, w_wc = 0, field_bad = 0, proto_bad = 0;
    logic [31:0] aw_log [8];
    logic [31:0] w_log [8];
    int          ar_cyc [8];

    int checks = 0, errors = 0;

    // AXI slave: decides readies/responses at the falling edge, logging handshakes.
    always @(negedge clk) begin
        int pend;
        cyc = cyc + 1;
        if (!rst_n) begin
            rsp = '0;
            aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            aw_wc = 0; w_wc = 0; field_bad = 0; proto_bad = 0;
        end else begin
            pend = ((aw_cnt < w_cnt) ? aw_cnt : w_cnt) - b_cnt;
            rsp.b_valid = (pend > 0);
            rsp.b.resp  = (b_cnt == err_idx) ? 2'b10 : RESP_OKAY;
            if (req.b_ready && pend <= 0) proto_bad++;
            if (rsp.b_valid && req.b_ready) b_cnt++;

            rsp.r_valid = (ar_cnt > r_cnt);
            rsp.r.data  = (r_cnt < 4) ? stat[r_cnt[1:0]] : 32'h0;
            rsp.r.resp  = RESP_OKAY;
            rsp.r.last  = 1'b1;
            if (rsp.r_valid && req.r_ready) r_cnt++;

            if (req.aw_valid) begin
                if (aw_cnt == 0 && aw_wc < aw_wait) begin
                    rsp.aw_ready = 1'b0;
                    aw_wc++;
                end else begin
                    rsp.aw_ready = 1'b1;
                    if (aw_cnt < 8) aw_log[aw_cnt] = req.aw.addr;
                    if (req.aw.size != 3'd2 || req.aw.burst != 2'b01 || req.aw.len != 8'd0 || req.aw.id != 4'd0) field_bad++;
                    aw_cnt++;
                end
            end else begin
                rsp.aw_ready = 1'b0;
            end

            if (req.w_valid) begin
                if (w_cnt == 0 && w_wc < w_wait) begin
                    rsp.w_ready = 1'b0;
                    w_wc++;
                end else begin
                    rsp.w_ready = 1'b1;
                    if (w_cnt < 8) w_log[w_cnt] = req.w.data;
                    if (req.w.strb != 4'hF || req.w.last != 1'b1) field_bad++;
                    w_cnt++;
                end
            end else begin
                rsp.w_ready = 1'b0;
            end

            rsp.ar_ready = req.ar_valid;
            if (req.ar_valid) begin
                if (ar_cnt < 8) ar_cyc[ar_cnt] = cyc;
                if (req.ar.addr != 32'h100 || req.ar.size != 3'd2 || req.ar.burst != 2'b01) field_bad++;
                ar_cnt++;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
        end
    endtask

    // Starts the block and waits (bounded) for done/error; k=0 means no pulse seen.
    task automatic start_and_wait(output int k, output bit busy1, output bit awv1);
        k = 0; busy1 = 1'b0; awv1 = 1'b0;
        @(negedge clk) start = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                busy1 = busy;
                awv1  = req.aw_valid;
            end
            if (done || error) begin
                k = n;
                break;
            end
        end
    endtask

    typedef struct {
        int          num;
        bit          poll;
        int          aw_wait;
        int          w_wait;
        int          err_idx;
        logic [31:0] mask;
        logic [31:0] st0, st1, st2, st3;
        bit          exp_done;
        int          exp_code;
        int          exp_cyc;
        int          exp_wr;
        int          exp_ar;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int  k;
        bit  b1, a1;
        rst_n = 1'b0; start = 1'b0; poll_en = 1'b0; num_cfg = 4'd0;
        poll_addr = 32'h100; poll_mask = 32'h1;
        for (int i = 0; i < 8; i++) begin
            cfg_addr[i] = 32'(4 * i);
            cfg_data[i] = 32'(17 * (i + 1));
        end
        for (int i = 0; i < 4; i++) stat[i] = 32'h0;

        //           num poll aww ww  err  mask   st0    st1    st2    st3   done code cyc wr ar
        vecs[0] = '{3, 1'b0, 0, 0, -1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 0,  7, 3, 0};
        vecs[1] = '{3, 1'b0, 3, 0, -1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 0, 10, 3, 0};
        vecs[2] = '{3, 1'b0, 0, 2, -1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 0,  9, 3, 0};
        vecs[3] = '{3, 1'b0, 0, 0,  1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1,  5, 2, 0};
        vecs[4] = '{0, 1'b1, 0, 0, -1, 32'h1, 32'h0, 32'h0, 32'h1, 32'h0, 1'b1, 0, 15, 0, 3};
        vecs[5] = '{0, 1'b1, 0, 0, -1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 3, 21, 0, 4};
        vecs[6] = '{1, 1'b1, 0, 0, -1, 32'h3, 32'h1, 32'h3, 32'h0, 32'h0, 1'b1, 0, 11, 1, 2};
        vecs[7] = '{0, 1'b0, 0, 0, -1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 0,  1, 0, 0};

        repeat (3) @(negedge clk);
        check("reset_req_zero", longint'(req == '0), 64'd1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_error", error, 0);
        check("reset_err_code", err_code, 0);

        for (int v = 0; v < 8; v++) begin
            @(negedge clk) rst_n = 1'b0;
            aw_wait = vecs[v].aw_wait; w_wait = vecs[v].w_wait; err_idx = vecs[v].err_idx;
            stat[0] = vecs[v].st0; stat[1] = vecs[v].st1; stat[2] = vecs[v].st2; stat[3] = vecs[v].st3;
            num_cfg = 4'(vecs[v].num); poll_en = vecs[v].poll; poll_mask = vecs[v].mask;
            @(negedge clk) rst_n = 1'b1;
            start_and_wait(k, b1, a1);
            check($sformatf("v%0d_pulse_cycle", v), k, vecs[v].exp_cyc);
            check($sformatf("v%0d_busy_first", v), b1, (vecs[v].exp_cyc > 1) ? 1 : 0);
            check($sformatf("v%0d_awvalid_first", v), a1, (vecs[v].num > 0) ? 1 : 0);
            check($sformatf("v%0d_done", v), done, vecs[v].exp_done ? 1 : 0);
            check($sformatf("v%0d_error", v), error, vecs[v].exp_done ? 0 : 1);
            check($sformatf("v%0d_busy_at_pulse", v), busy, 0);
            check($sformatf("v%0d_err_code", v), err_code, vecs[v].exp_code);
            check($sformatf("v%0d_aw_count", v), aw_cnt, vecs[v].exp_wr);
            check($sformatf("v%0d_w_count", v), w_cnt, vecs[v].exp_wr);
            check($sformatf("v%0d_ar_count", v), ar_cnt, vecs[v].exp_ar);
            check($sformatf("v%0d_fixed_fields", v), field_bad, 0);
            check($sformatf("v%0d_bready_early", v), proto_bad, 0);
            for (int i = 0; i < vecs[v].exp_wr; i++) begin
                check($sformatf("v%0d_aw_addr%0d", v, i), aw_log[i], 4 * i);
                check($sformatf("v%0d_w_data%0d", v, i), w_log[i], 17 * (i + 1));
            end
            for (int i = 0; i + 1 < vecs[v].exp_ar; i++) begin
                check($sformatf("v%0d_ar_gap%0d", v, i), ar_cyc[i+1] - ar_cyc[i], 6);
            end
            @(negedge clk);
            check($sformatf("v%0d_pulse_len", v), done | error, 0);
            check($sformatf("v%0d_err_code_held", v), err_code, vecs[v].exp_code);
        end

        // Reset while a write request is outstanding, then a fresh sequence.
        @(negedge clk) rst_n = 1'b0;
        aw_wait = 20; w_wait = 20; err_idx = -1; num_cfg = 4'd3; poll_en = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
        check("midrst_awvalid_before", req.aw_valid, 1);
        check("midrst_wvalid_before", req.w_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_req_zero", longint'(req == '0), 64'd1);
        check("midrst_busy", busy, 0);
        rst_n = 1'b1; aw_wait = 0; w_wait = 0;
        @(negedge clk);
        start_and_wait(k, b1, a1);
        check("midrst_restart_cycle", k, 7);
        check("midrst_restart_done", done, 1);
        check("midrst_restart_aw_count", aw_cnt, 3);
        check("midrst_restart_w_count", w_cnt, 3);
        check("midrst_restart_first_addr", aw_log[0], 0);
        check("midrst_restart_first_data", w_log[0], 17);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
